// File: rtl/alu_serial_tx.sv
// Serial-frame transmitter for the ALU `sin` line: 8 data frames plus one CRC4 command frame per request.
// Optional ALU_TX_FRAME_GAP_EN inserts one idle bit-time between consecutive frames.
module alu_serial_tx #(
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic [1:0]  err_mode,
    output logic        sin,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [7:0] BIT_LAST   = 8'(BIT_CYCLES - 1);
    localparam logic [3:0] LAST_BIT   = 4'd10;
    localparam logic [3:0] FRAME_CMD  = 4'd8;
    localparam logic [3:0] FRAME_SKIP = 4'd6;

    state_t      state_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [2:0]  op_r;
    logic [1:0]  err_r;
    logic [2:0]  op_tx_r;
    logic [3:0]  crc_r;
    logic [10:0] shreg_r;
    logic [7:0]  bit_cnt_r;
    logic [3:0]  bit_idx_r;
    logic [3:0]  frame_r;

    logic [2:0]  op_sel_s;
    logic [3:0]  crc_s;
    logic [3:0]  next_frame_s;
    logic [10:0] next_word_s;
    logic        last_frame_s;
    logic        gap_active_s;

    // CRC4, polynomial x^4+x+1, initial 0, MSB first
    function automatic logic [3:0] crc4(input logic [67:0] v);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ v[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [10:0] make_frame(input logic is_cmd, input logic [7:0] payload);
        return {1'b0, is_cmd, payload, 1'b1};
    endfunction

    // Error-mode adjustments, CRC and selection of the frame that follows the current one
    always_comb begin
        op_sel_s = (err_r == 2'b11) ? 3'b010 : op_r;
        crc_s    = crc4({b_r, a_r, 1'b1, op_sel_s}) ^ ((err_r == 2'b10) ? 4'b0001 : 4'b0000);
        last_frame_s = (frame_r == FRAME_CMD);
        if (err_r == 2'b01 && frame_r == FRAME_SKIP) begin
            next_frame_s = FRAME_CMD;
        end else begin
            next_frame_s = frame_r + 4'd1;
        end
        case (next_frame_s)
            4'd0:    next_word_s = make_frame(1'b0, b_r[31:24]);
            4'd1:    next_word_s = make_frame(1'b0, b_r[23:16]);
            4'd2:    next_word_s = make_frame(1'b0, b_r[15:8]);
            4'd3:    next_word_s = make_frame(1'b0, b_r[7:0]);
            4'd4:    next_word_s = make_frame(1'b0, a_r[31:24]);
            4'd5:    next_word_s = make_frame(1'b0, a_r[23:16]);
            4'd6:    next_word_s = make_frame(1'b0, a_r[15:8]);
            4'd7:    next_word_s = make_frame(1'b0, a_r[7:0]);
            default: next_word_s = make_frame(1'b1, {1'b0, op_tx_r, crc_r});
        endcase
    end

`ifdef ALU_TX_FRAME_GAP_EN
    logic gap_r;
    assign gap_active_s = gap_r;

    // Gap flag: armed when a frame finishes and another follows, cleared after one bit-time
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_r <= 1'b0;
        end else if (state_r == SHIFT && bit_cnt_r == BIT_LAST) begin
            if (gap_r) begin
                gap_r <= 1'b0;
            end else begin
                gap_r <= (bit_idx_r == LAST_BIT) && !last_frame_s;
            end
        end else if (state_r != SHIFT) begin
            gap_r <= 1'b0;
        end else begin
            gap_r <= gap_r;
        end
    end
`else
    assign gap_active_s = 1'b0;
`endif

    // Main FSM; sin is registered so each bit appears one cycle after its shift-register slot
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            sin       <= 1'b1;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            op_r      <= 3'd0;
            err_r     <= 2'd0;
            op_tx_r   <= 3'd0;
            crc_r     <= 4'd0;
            shreg_r   <= 11'h7FF;
            bit_cnt_r <= 8'd0;
            bit_idx_r <= 4'd0;
            frame_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    sin  <= 1'b1;
                    if (req_valid && req_ready) begin
                        a_r       <= a;
                        b_r       <= b;
                        op_r      <= op;
                        err_r     <= err_mode;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= LOAD;
                    end else begin
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                LOAD: begin
                    op_tx_r   <= op_sel_s;
                    crc_r     <= crc_s;
                    shreg_r   <= make_frame(1'b0, b_r[31:24]);
                    frame_r   <= 4'd0;
                    bit_cnt_r <= 8'd0;
                    bit_idx_r <= 4'd0;
                    sin       <= 1'b1;
                    state_r   <= SHIFT;
                end
                SHIFT: begin
                    sin <= gap_active_s ? 1'b1 : shreg_r[10];
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_r <= 8'd0;
                        if (gap_active_s) begin
                            bit_idx_r <= 4'd0;
                        end else if (bit_idx_r == LAST_BIT) begin
                            bit_idx_r <= 4'd0;
                            if (last_frame_s) begin
                                state_r <= DONE;
                            end else begin
                                frame_r <= next_frame_s;
                                shreg_r <= next_word_s;
                            end
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                            shreg_r   <= {shreg_r[9:0], 1'b1};
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    sin     <= 1'b1;
                    frame_r <= 4'd0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_tx.sv
// Bench for alu_serial_tx: queue-based frame model, per-cycle compare on two instances (BIT_CYCLES 1 and 3).
module tb_alu_serial_tx;

`ifdef ALU_TX_FRAME_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst1, rst3, rv1, rv3;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [1:0]  err_mode;
    logic        rr1, sin1, busy1, done1;
    logic        rr3, sin3, busy3, done3;

    always #5 clk = ~clk;

    alu_serial_tx #(.BIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .req_valid(rv1), .req_ready(rr1),
        .a(a), .b(b), .op(op), .err_mode(err_mode),
        .sin(sin1), .busy(busy1), .done(done1)
    );

    alu_serial_tx #(.BIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(rv3), .req_ready(rr3),
        .a(a), .b(b), .op(op), .err_mode(err_mode),
        .sin(sin3), .busy(busy3), .done(done3)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic        use3 = 1'b0;
    logic [3:0]  exp_q[$];      // {sin, busy, done, req_ready} per cycle
    logic        stream_q[$];   // expected serial bits of one packet
    logic [10:0] cmd_word;
    logic [3:0]  act_v, exp_v;

    // Per-cycle compare against the expected queue, away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = use3 ? {sin3, busy3, done3, rr3} : {sin1, busy1, done1, rr1};
            n_vec++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle t=%0t bc=%0d {sin,busy,done,ready} got %b expected %b",
                         $time, use3 ? 3 : 1, act_v, exp_v);
            end
        end
    end

    // Reference CRC as polynomial division of {B,A,1,OP,0000} by 10011
    function automatic logic [3:0] m_crc(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop);
        logic [71:0] r;
        r = {ib, ia, 1'b1, iop, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    task automatic push_frame(input logic typ, input logic [7:0] p);
        if (GAP != 0 && stream_q.size() > 0) stream_q.push_back(1'b1);
        stream_q.push_back(1'b0);
        stream_q.push_back(typ);
        for (int i = 7; i >= 0; i--) stream_q.push_back(p[i]);
        stream_q.push_back(1'b1);
    endtask

    task automatic build(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop, input logic [1:0] ierr);
        logic [7:0] bytes [8];
        logic [2:0] opx;
        logic [3:0] c;
        bytes[0] = ib[31:24]; bytes[1] = ib[23:16]; bytes[2] = ib[15:8]; bytes[3] = ib[7:0];
        bytes[4] = ia[31:24]; bytes[5] = ia[23:16]; bytes[6] = ia[15:8]; bytes[7] = ia[7:0];
        stream_q.delete();
        for (int k = 0; k < 8; k++) begin
            if (!(ierr == 2'b01 && k == 7)) push_frame(1'b0, bytes[k]);
        end
        opx = (ierr == 2'b11) ? 3'b010 : iop;
        c   = m_crc(ia, ib, opx);
        if (ierr == 2'b10) c = c ^ 4'b0001;
        cmd_word = {1'b0, 1'b1, 1'b0, opx, c, 1'b1};
        push_frame(1'b1, {1'b0, opx, c});
    endtask

    function automatic logic [7:0] payload_of(input int k);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[7-i] = stream_q[k * (11 + GAP) + 2 + i];
        return p;
    endfunction

    task automatic check_lit(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Drive one request (called while idle with ready high); optionally reset after abort_after cycles
    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] iop,
                        input logic [1:0] ierr, input logic hold, input int abort_after);
        int bc;
        bc = use3 ? 3 : 1;
        a = ia; b = ib; op = iop; err_mode = ierr;
        if (use3) rv3 = 1'b1; else rv1 = 1'b1;
        build(ia, ib, iop, ierr);
        @(posedge clk);
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b1100);
        foreach (stream_q[i]) repeat (bc) exp_q.push_back({stream_q[i], 3'b100});
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1001);
        #1;
        a = $urandom; b = $urandom; op = 3'($urandom); err_mode = 2'($urandom);
        if (!hold) begin rv1 = 1'b0; rv3 = 1'b0; end
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            #1;
            rv1 = 1'b0; rv3 = 1'b0;
            if (use3) rst3 = 1'b1; else rst1 = 1'b1;
            exp_q.delete();
            @(posedge clk);
            exp_q.push_back(4'b1001);
            #1;
            rst1 = 1'b0; rst3 = 1'b0;
            repeat (320) exp_q.push_back(4'b1001);
        end
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired got running expected finished");
        $fatal(1);
    end

    initial begin
        rst1 = 1'b1; rst3 = 1'b1; rv1 = 1'b0; rv3 = 1'b0;
        a = 32'd0; b = 32'd0; op = 3'd0; err_mode = 2'd0;
        @(posedge clk);
        #1;
        exp_q.push_back(4'b1001);
        drain();
        use3 = 1'b1;
        exp_q.push_back(4'b1001);
        drain();
        use3 = 1'b0;
        @(posedge clk);
        #1;
        rst1 = 1'b0; rst3 = 1'b0;
        exp_q.push_back(4'b1001);
        exp_q.push_back(4'b1001);
        drain();

        // Model pins
        build(32'd0, 32'd0, 3'b000, 2'b00);
        check_lit("zero_len", stream_q.size(), 99 + 8 * GAP);
        check_lit("zero_crc", m_crc(32'd0, 32'd0, 3'b000), 4'b1011);
        check_lit("zero_cmd", cmd_word, 11'b0_1_0_000_1011_1);
        check_lit("zero_f0", payload_of(0), 8'h00);
        build(32'hFFFF_FFFF, 32'h0102_0304, 3'b100, 2'b00);
        check_lit("order_f0", payload_of(0), 8'h01);
        check_lit("order_f3", payload_of(3), 8'h04);
        check_lit("order_f4", payload_of(4), 8'hFF);
        build(32'd0, 32'd0, 3'b000, 2'b01);
        check_lit("short_len", stream_q.size(), 88 + 7 * GAP);
        build(32'd0, 32'd0, 3'b000, 2'b10);
        check_lit("badcrc_cmd", cmd_word, 11'b0_1_0_000_1010_1);
        build(32'd0, 32'd0, 3'b101, 2'b11);
        check_lit("badop_cmd", cmd_word, 11'b0_1_0_010_1101_1);

        // BIT_CYCLES = 1
        send(32'd0, 32'd0, 3'b000, 2'b00, 1'b0, 0);
        send(32'hFFFF_FFFF, 32'h0102_0304, 3'b100, 2'b00, 1'b0, 0);
        send(32'd0, 32'd0, 3'b000, 2'b01, 1'b0, 0);
        send(32'd0, 32'd0, 3'b000, 2'b10, 1'b0, 0);
        send(32'd0, 32'd0, 3'b101, 2'b11, 1'b0, 0);
        send(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 2'b00, 1'b0, 0);
        send(32'hA5A5_0F0F, 32'h8000_0001, 3'b110, 2'b00, 1'b0, 0);
        send(32'hDEAD_BEEF, 32'hCAFE_F00D, 3'b101, 2'b10, 1'b0, 0);

        // BIT_CYCLES = 3: back-to-back requests with valid held, then reset in frame 4
        use3 = 1'b1;
        send(32'h0000_00FF, 32'h1111_2222, 3'b100, 2'b00, 1'b1, 0);
        send(32'h7654_3210, 32'h0F0E_0D0C, 3'b101, 2'b01, 1'b0, 0);
        send(32'h1357_9BDF, 32'h2468_ACE0, 3'b000, 2'b00, 1'b0, 110);
        send(32'h0000_0001, 32'h8000_0000, 3'b011, 2'b11, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
